// File: rtl/tile_pkg.sv
// tile_pkg
//   Shared definitions for the collision scheduler: default tile-map
//   geometry, the scheduler state encoding and the probe index type.
//   No ports; imported by collision_scheduler and probe_addr.
package tile_pkg;

   localparam int DEF_TILE_SHIFT = 4;
   localparam int DEF_MAP_COLS   = 40;
   localparam int DEF_MAP_ROWS   = 30;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_ISSUE,
      ST_CAPTURE,
      ST_COMMIT
   } sched_state_t;

   // Probe order is the enum order: the sequencer simply counts upward.
   typedef enum logic [1:0] {
      PROBE_LEFT,
      PROBE_RIGHT,
      PROBE_UP,
      PROBE_DOWN
   } probe_idx_t;

endpackage

// File: rtl/probe_addr.sv
// probe_addr
//   Combinational tile address for one collision probe around the ball.
//   Ports:
//     x, y, s  : ball centre and half-size in pixels (10-bit unsigned)
//     dir      : which neighbour this probe looks at
//     row, col : tile coordinate of the probe pixel
//     oor      : probe lies outside the tile map (treated as solid)
module probe_addr
   import tile_pkg::*;
#(
   parameter int TILE_SHIFT = DEF_TILE_SHIFT,
   parameter int MAP_COLS   = DEF_MAP_COLS,
   parameter int MAP_ROWS   = DEF_MAP_ROWS
) (
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [9:0]  s,
   input  probe_idx_t  dir,
   output logic [4:0]  row,
   output logic [5:0]  col,
   output logic        oor
);

   localparam logic [9:0] COL_LIMIT = 10'(MAP_COLS);
   localparam logic [9:0] ROW_LIMIT = 10'(MAP_ROWS);

   logic [9:0] px;
   logic [9:0] py;
   logic [9:0] tile_x;
   logic [9:0] tile_y;

   // Arithmetic stays 10-bit on purpose: a probe left of or above the
   // screen wraps to a large value, which the range test then flags.
   always_comb begin
      px = x;
      py = y;
      case (dir)
         PROBE_LEFT:  px = x - s - 10'd1;
         PROBE_RIGHT: px = x + s + 10'd1;
         PROBE_UP:    py = y - s - 10'd1;
         default:     py = y + s + 10'd1;
      endcase
      tile_x = px >> TILE_SHIFT;
      tile_y = py >> TILE_SHIFT;
      oor    = (tile_x >= COL_LIMIT) || (tile_y >= ROW_LIMIT);
      col    = tile_x[5:0];
      row    = tile_y[4:0];
   end

endmodule

// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Shares the single tile-map read port between the renderer and a
//   once-per-frame sequence of four collision probes around the ball.
//   Ports:
//     Clk, Reset_n             : clock, async active-low reset
//     frame_clk                : frame strobe; its rising edge starts a sequence
//     BallX, BallY, BallS      : ball centre and half-size
//     pix_req/pix_row/pix_col  : renderer lookup (always wins the port)
//     pix_valid/pix_tile       : renderer result, one cycle after pix_req
//     mem_row/mem_col/mem_data : tile-map read port, 1-cycle registered read
//     blk_left..blk_down       : neighbour tile solid, updated together
//     busy, done, overrun      : sequence status; overrun is sticky
module collision_scheduler
   import tile_pkg::*;
#(
   parameter int TILE_SHIFT = DEF_TILE_SHIFT,
   parameter int MAP_COLS   = DEF_MAP_COLS,
   parameter int MAP_ROWS   = DEF_MAP_ROWS
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic [9:0]  BallX,
   input  logic [9:0]  BallY,
   input  logic [9:0]  BallS,
   input  logic        pix_req,
   input  logic [4:0]  pix_row,
   input  logic [5:0]  pix_col,
   output logic        pix_tile,
   output logic        pix_valid,
   output logic [4:0]  mem_row,
   output logic [5:0]  mem_col,
   input  logic        mem_data,
   output logic        blk_left,
   output logic        blk_right,
   output logic        blk_up,
   output logic        blk_down,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   sched_state_t state, state_n;
   probe_idx_t   probe, probe_n;

   logic        frame_q;
   logic        frame_edge;
   logic        drive_probe;
   logic        probe_bit;
   logic [9:0]  ball_x, ball_y, ball_s;
   logic [4:0]  calc_row [4];
   logic [5:0]  calc_col [4];
   logic        calc_oor [4];
   logic [4:0]  probe_row [4];
   logic [5:0]  probe_col [4];
   logic        probe_oor [4];
   logic        sh_left, sh_right, sh_up;

   assign frame_edge = frame_clk & ~frame_q;
   // An out-of-range probe never touched memory, so it resolves solid.
   assign probe_bit  = probe_oor[probe] | mem_data;
   assign pix_tile   = pix_valid & mem_data;

   for (genvar g = 0; g < 4; g++) begin : g_probe
      probe_addr #(
         .TILE_SHIFT (TILE_SHIFT),
         .MAP_COLS   (MAP_COLS),
         .MAP_ROWS   (MAP_ROWS)
      ) u_probe_addr (
         .x   (ball_x),
         .y   (ball_y),
         .s   (ball_s),
         .dir (probe_idx_t'(g)),
         .row (calc_row[g]),
         .col (calc_col[g]),
         .oor (calc_oor[g])
      );
   end

   // State and probe index registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
         probe <= PROBE_LEFT;
      end else begin
         state <= state_n;
         probe <= probe_n;
      end
   end

   // Sequencer. ISSUE waits while the renderer owns the port, except for
   // out-of-range probes which need no access and move straight on.
   always_comb begin
      state_n     = state;
      probe_n     = probe;
      drive_probe = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frame_edge) state_n = ST_CALC;
         end
         ST_CALC: begin
            state_n = ST_ISSUE;
            probe_n = PROBE_LEFT;
         end
         ST_ISSUE: begin
            if (probe_oor[probe]) begin
               state_n = ST_CAPTURE;
            end else if (!pix_req) begin
               state_n     = ST_CAPTURE;
               drive_probe = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (probe == PROBE_DOWN) begin
               state_n = ST_COMMIT;
            end else begin
               state_n = ST_ISSUE;
               probe_n = probe_idx_t'(probe + 2'd1);
            end
         end
         ST_COMMIT: begin
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Read-port mux. Held at zero during reset even if the renderer asks.
   always_comb begin
      mem_row = '0;
      mem_col = '0;
      if (Reset_n) begin
         if (pix_req) begin
            mem_row = pix_row;
            mem_col = pix_col;
         end else if (drive_probe) begin
            mem_row = probe_row[probe];
            mem_col = probe_col[probe];
         end
      end
   end

   // Datapath: edge register, ball snapshot, probe addresses, shadow
   // results and the status outputs. The final probe bit goes directly
   // into blk_down so all four outputs change on the same edge as done.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_q   <= 1'b0;
         ball_x    <= '0;
         ball_y    <= '0;
         ball_s    <= '0;
         for (int i = 0; i < 4; i++) begin
            probe_row[i] <= '0;
            probe_col[i] <= '0;
            probe_oor[i] <= 1'b0;
         end
         sh_left   <= 1'b0;
         sh_right  <= 1'b0;
         sh_up     <= 1'b0;
         blk_left  <= 1'b0;
         blk_right <= 1'b0;
         blk_up    <= 1'b0;
         blk_down  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         pix_valid <= 1'b0;
      end else begin
         frame_q   <= frame_clk;
         pix_valid <= pix_req;
         done      <= 1'b0;
         if (frame_edge) begin
            if (state == ST_IDLE) begin
               ball_x <= BallX;
               ball_y <= BallY;
               ball_s <= BallS;
               busy   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
         if (state == ST_CALC) begin
            probe_row <= calc_row;
            probe_col <= calc_col;
            probe_oor <= calc_oor;
         end
         if (state == ST_CAPTURE) begin
            case (probe)
               PROBE_LEFT:  sh_left  <= probe_bit;
               PROBE_RIGHT: sh_right <= probe_bit;
               PROBE_UP:    sh_up    <= probe_bit;
               default: begin
                  blk_left  <= sh_left;
                  blk_right <= sh_right;
                  blk_up    <= sh_up;
                  blk_down  <= probe_bit;
                  done      <= 1'b1;
               end
            endcase
         end
         if (state == ST_COMMIT) busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler
//   Directed bench for collision_scheduler with a registered tile-map
//   model. Expected values are hand-derived from the ball geometry.
module tb_collision_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_clk;
   logic [9:0]  ball_x, ball_y, ball_s;
   logic        pix_req;
   logic [4:0]  pix_row;
   logic [5:0]  pix_col;
   logic        pix_tile, pix_valid;
   logic [4:0]  mem_row;
   logic [5:0]  mem_col;
   logic        mem_data = 1'b0;
   logic        blk_left, blk_right, blk_up, blk_down;
   logic        busy, done, overrun;

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   bit saw_col63 = 1'b0;
   bit hold_frame = 1'b0;
   bit tile_map [30][40];

   always #5 clk = ~clk;

   collision_scheduler dut (
      .Clk       (clk),
      .Reset_n   (reset_n),
      .frame_clk (frame_clk),
      .BallX     (ball_x),
      .BallY     (ball_y),
      .BallS     (ball_s),
      .pix_req   (pix_req),
      .pix_row   (pix_row),
      .pix_col   (pix_col),
      .pix_tile  (pix_tile),
      .pix_valid (pix_valid),
      .mem_row   (mem_row),
      .mem_col   (mem_col),
      .mem_data  (mem_data),
      .blk_left  (blk_left),
      .blk_right (blk_right),
      .blk_up    (blk_up),
      .blk_down  (blk_down),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   // Tile map with a one-cycle registered read.
   always @(posedge clk) begin
      if (mem_row < 5'd30 && mem_col < 6'd40) mem_data <= tile_map[mem_row][mem_col];
      else mem_data <= 1'b0;
   end

   // Count done pulses and watch for an access to tile column 63.
   always @(negedge clk) begin
      if (done === 1'b1) done_count++;
      if (busy === 1'b1 && pix_req === 1'b0 && mem_col === 6'd63) saw_col63 = 1'b1;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                                input logic [9:0] s);
      ball_x    = x;
      ball_y    = y;
      ball_s    = s;
      frame_clk = 1'b1;
   endtask

   task automatic waitForDone(input int start, input int limit, output int cycles);
      cycles = start;
      while (done !== 1'b1 && cycles < limit) begin
         stepCycle();
         cycles++;
         if (!hold_frame) frame_clk = 1'b0;
      end
   endtask

   function automatic logic [3:0] blkVec();
      return {blk_left, blk_right, blk_up, blk_down};
   endfunction

   task automatic runSequence(input string tag, input logic [9:0] x, input logic [9:0] y,
                              input logic [9:0] s, input logic [3:0] exp_blk);
      int n;
      applyStimulus(x, y, s);
      waitForDone(0, 40, n);
      checkOutput({tag, "_latency"}, n, 10);
      checkOutput({tag, "_blk"}, blkVec(), exp_blk);
      stepCycle();
      checkOutput({tag, "_idle"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int n;
      int dc0;

      // Reset with the renderer requesting: address port must stay at zero.
      reset_n   = 1'b0;
      frame_clk = 1'b0;
      ball_x    = '0;
      ball_y    = '0;
      ball_s    = '0;
      pix_req   = 1'b1;
      pix_row   = 5'd9;
      pix_col   = 6'd9;
      repeat (2) stepCycle();
      checkOutput("reset_mem_addr", {mem_row, mem_col}, 11'd0);
      checkOutput("reset_blk", blkVec(), 4'b0000);
      checkOutput("reset_status", {busy, done, overrun}, 3'b000);
      checkOutput("reset_pix", {pix_valid, pix_tile}, 2'b00);
      pix_req = 1'b0;
      reset_n = 1'b1;
      repeat (2) stepCycle();

      // Empty map, frame strobe held high to confirm a level does not retrigger.
      $display("[TB] empty map, held frame strobe");
      dc0 = done_count;
      hold_frame = 1'b1;
      applyStimulus(10'd100, 10'd100, 10'd4);
      stepCycle();
      checkOutput("busy_after_edge", busy, 1'b1);
      waitForDone(1, 40, n);
      checkOutput("empty_latency", n, 10);
      checkOutput("empty_blk", blkVec(), 4'b0000);
      checkOutput("commit_busy", busy, 1'b1);
      stepCycle();
      checkOutput("busy_drop", {busy, done}, 2'b00);
      repeat (15) stepCycle();
      checkOutput("level_no_retrigger", {busy, overrun}, 2'b00);
      checkOutput("level_done_count", done_count, dc0 + 1);
      hold_frame = 1'b0;
      frame_clk  = 1'b0;
      stepCycle();

      // Solid tile at row 6, col 7.
      $display("[TB] single solid tile");
      tile_map[6][7] = 1'b1;
      runSequence("right_clear", 10'd100, 10'd100, 10'd4, 4'b0000);
      runSequence("right_solid", 10'd108, 10'd100, 10'd4, 4'b0100);

      // Out-of-range probes and map boundaries.
      $display("[TB] wrap and boundary probes");
      saw_col63 = 1'b0;
      runSequence("left_wrap", 10'd3, 10'd100, 10'd4, 4'b1000);
      checkOutput("left_wrap_no_access", saw_col63, 1'b0);
      runSequence("up_wrap", 10'd100, 10'd2, 10'd4, 4'b0010);
      runSequence("bottom_edge", 10'd100, 10'd476, 10'd4, 4'b0001);

      // Renderer owns the port for 20 cycles starting at the first ISSUE.
      $display("[TB] renderer priority");
      applyStimulus(10'd100, 10'd100, 10'd4);
      stepCycle();
      frame_clk = 1'b0;
      stepCycle();
      n = 2;
      for (int i = 0; i < 20; i++) begin
         pix_req = 1'b1;
         pix_row = 5'd6;
         pix_col = 6'(5 + (i % 3));
         #1;
         checkOutput("rend_mem_addr", {mem_row, mem_col}, {5'd6, 6'(5 + (i % 3))});
         stepCycle();
         n++;
         checkOutput("rend_valid", pix_valid, 1'b1);
         checkOutput("rend_tile", pix_tile, ((i % 3) == 2) ? 1'b1 : 1'b0);
      end
      pix_req = 1'b0;
      stepCycle();
      n++;
      checkOutput("rend_valid_drop", pix_valid, 1'b0);
      waitForDone(n, 60, n);
      checkOutput("rend_latency", n, 30);
      checkOutput("rend_blk", blkVec(), 4'b0000);
      stepCycle();

      // Second frame edge three cycles into a sequence.
      $display("[TB] overrun while busy");
      checkOutput("overrun_clear", overrun, 1'b0);
      dc0 = done_count;
      applyStimulus(10'd108, 10'd100, 10'd4);
      stepCycle();
      frame_clk = 1'b0;
      ball_x    = 10'd100;
      stepCycle();
      stepCycle();
      frame_clk = 1'b1;
      stepCycle();
      frame_clk = 1'b0;
      checkOutput("overrun_set", overrun, 1'b1);
      waitForDone(4, 40, n);
      checkOutput("overrun_latency", n, 10);
      checkOutput("overrun_blk", blkVec(), 4'b0100);
      repeat (15) stepCycle();
      checkOutput("overrun_single_done", done_count, dc0 + 1);
      checkOutput("overrun_sticky", {overrun, busy}, 2'b10);

      // Reset during CAPTURE of the up probe.
      $display("[TB] reset mid-sequence");
      applyStimulus(10'd108, 10'd100, 10'd4);
      repeat (7) begin
         stepCycle();
         frame_clk = 1'b0;
      end
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_blk", blkVec(), 4'b0000);
      checkOutput("midreset_status", {busy, done, overrun}, 3'b000);
      stepCycle();
      reset_n = 1'b1;
      repeat (3) stepCycle();
      checkOutput("postreset_quiet", {blkVec(), busy}, 5'b00000);
      runSequence("postreset_seq", 10'd108, 10'd100, 10'd4, 4'b0100);

      // Frame edge landing in the COMMIT cycle is dropped.
      $display("[TB] edge during commit");
      checkOutput("commit_overrun_clear", overrun, 1'b0);
      applyStimulus(10'd100, 10'd100, 10'd4);
      waitForDone(0, 40, n);
      checkOutput("commit_latency", n, 10);
      frame_clk = 1'b1;
      stepCycle();
      checkOutput("commit_edge_overrun", {overrun, busy}, 2'b10);
      repeat (3) stepCycle();
      checkOutput("commit_edge_dropped", busy, 1'b0);
      checkOutput("commit_blk", blkVec(), 4'b0000);
      frame_clk = 1'b0;
      stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  TILE_SHIFT, 4, log2 of tile edge in pixels
  MAP_COLS, 40, tile columns
  MAP_ROWS, 30, tile rows
REQ-002 Ports (name, direction, width, meaning), one per line:
  Clk  in  1  single clock, rising edge
  Reset_n  in  1  asynchronous, active-low reset
  frame_clk  in  1  VS-derived frame strobe, synchronous to Clk
  BallX, BallY, BallS  in  10 each  ball centre and half-size
  pix_req  in  1  renderer tile lookup request
  pix_row  in  5  renderer tile row
  pix_col  in  6  renderer tile column
  pix_tile  out  1  renderer lookup result
  pix_valid  out  1  pix_tile valid
  mem_row  out  5  tile map read row
  mem_col  out  6  tile map read column
  mem_data  in  1  tile bit, registered, 1-cycle read latency
  blk_left, blk_right, blk_up, blk_down  out  1 each  neighbour tile solid
  busy  out  1  probe sequence in progress
  done  out  1  one-cycle pulse on commit
  overrun  out  1  sticky: frame edge arrived while busy

Function
REQ-003 The block shall share the single tile-map read port between renderer and a once-per-frame four-probe collision sequence.
REQ-004 A frame edge shall be the rising edge of frame_clk, detected via a registered copy; a level held high shall not retrigger.
REQ-005 On a frame edge in IDLE, the block shall snapshot BallX/BallY/BallS, assert busy next cycle and enter CALC.
REQ-006 CALC (1 cycle) shall compute probe addresses in 10-bit unsigned arithmetic, shifting by TILE_SHIFT: left (X-S-1, Y), right (X+S+1, Y), up (X, Y-S-1), down (X, Y+S+1).
REQ-007 A probe whose column >= MAP_COLS or row >= MAP_ROWS, including 10-bit underflow wrap, shall resolve solid (1) without a memory access.
REQ-008 States: IDLE -> CALC -> ISSUE -> CAPTURE -> (ISSUE for next probe | COMMIT) -> IDLE; probe order left, right, up, down.
REQ-009 Renderer has strict priority: when pix_req=1, mem_row/mem_col shall carry pix_row/pix_col and ISSUE shall stall.
REQ-010 pix_valid shall equal pix_req delayed one cycle; pix_tile shall equal mem_data in that cycle; back-to-back pix_req shall be sustained at one per cycle.
REQ-011 CAPTURE shall always follow the cycle in which the probe address was driven; mem_data captured there belongs to the probe, never the renderer.
REQ-012 Probe results shall be held in shadow registers; COMMIT shall update all four blk_* outputs in the same cycle, pulse done, deassert busy the following cycle.
REQ-013 Minimum sequence latency, no pix_req, all probes in range: frame edge to done = 10 cycles.
REQ-014 A frame edge while busy shall set overrun and shall be dropped; the running sequence continues unchanged.
REQ-015 A frame edge coincident with COMMIT shall count as busy (dropped, overrun set).

Reset
REQ-016 Reset_n low shall asynchronously force IDLE; blk_*, busy, done, pix_valid, pix_tile, overrun, edge register = 0; mem_row/mem_col = 0.
REQ-017 Reset mid-sequence shall discard shadow results; blk_* shall not reflect partial probes.

Structure
REQ-018 Package tile_pkg shall hold TILE_SHIFT, MAP_COLS, MAP_ROWS defaults and the state enum and probe-index typedef.
REQ-019 One sub-module, probe_addr, shall hold the combinational address/out-of-range calculation for one probe.

Verification
REQ-020 Ball (100,100,S=4), all-zero map, no pix_req, frame edge -> done 10 cycles later, blk_* = 0000.
REQ-021 Ball (3,100,S=4) -> left X-S-1 wraps to 1022, column 63 -> blk_left=1 with no memory address issued for it.
REQ-022 pix_req held high 20 cycles after frame edge -> renderer served every cycle with pix_valid/pix_tile correct; done delayed by exactly 20 cycles.
REQ-023 Solid tile at (row 6, col 7), ball (100,100,S=4) -> right probe column 105>>4=6, clear; ball (108,100,S=4) -> column 113>>4=7 -> blk_right=1 only.
REQ-024 Second frame edge 3 cycles after first -> overrun=1 stays set; blk_* from first sequence only.
REQ-025 Reset_n low during CAPTURE of probe 2 -> blk_* = 0, busy=0 immediately; next frame edge completes normally.
